// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage.
// Op codes, FSM states and reset/zero constants live here.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_e;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0;

    function automatic logic is_load(input mem_op_e op);
        return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
    endfunction

    function automatic logic is_aligned(input mem_op_e op, input logic [1:0] off);
        unique case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return !off[0];
            MEM_OP_LW, MEM_OP_SW:             return off == 2'b00;
            default:                          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Lane extraction and sign/zero extension of little-endian load data.
// Purely combinational so a future cache path can share it.
module load_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  mem_op_e           op_i,
    input  logic [1:0]        off_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        unique case (off_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        unique case (op_i)
            MEM_OP_LB:  data_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
            MEM_OP_LBU: data_o = {{(DATA_W-8){1'b0}}, byte_v};
            MEM_OP_LH:  data_o = {{(DATA_W-16){half_v[15]}}, half_v};
            MEM_OP_LHU: data_o = {{(DATA_W-16){1'b0}}, half_v};
            default:    data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers execute results, runs loads/stores over
// a req/ack bus, stalls upstream while busy, flags misalign and timeout.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [3:0]            mem_op_i,
    input  logic [DATA_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     ans_i,
    input  logic [DATA_W-1:0]     store_data_i,
    input  logic [REG_ADDR_W-1:0] write_addr_i,
    input  logic                  write_enable_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [DATA_W-1:0]     bus_addr_o,
    output logic [3:0]            bus_sel_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic [REG_ADDR_W-1:0] write_addr_o,
    output logic                  write_enable_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  misalign_o,
    output logic                  bus_err_o
);

    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    mem_op_e               op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic [REG_ADDR_W-1:0] cap_wa_q, cap_wa_d;
    logic                  cap_we_q, cap_we_d;
    logic                  discard_q, discard_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [DATA_W-1:0]     bus_addr_q, bus_addr_d;
    logic [3:0]            bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;
    logic [REG_ADDR_W-1:0] write_addr_q, write_addr_d;
    logic                  write_enable_q, write_enable_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  misalign_q, misalign_d;
    logic                  bus_err_q, bus_err_d;

    mem_op_e           op_in;
    logic              timeout_hit;
    logic [DATA_W-1:0] load_val;

    assign op_in = mem_op_e'(mem_op_i);

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .op_i    (op_q),
        .off_i   (off_q),
        .rdata_i (bus_rdata_i),
        .data_o  (load_val)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        off_d          = off_q;
        cap_wa_d       = cap_wa_q;
        cap_we_d       = cap_we_q;
        discard_d      = discard_q;
        bus_req_d      = bus_req_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_sel_d      = bus_sel_q;
        bus_wdata_d    = bus_wdata_q;
        write_addr_d   = write_addr_q;
        write_enable_d = 1'b0;
        wdata_d        = wdata_q;
        misalign_d     = 1'b0;
        bus_err_d      = 1'b0;
        stall_o        = 1'b0;
        timeout_hit    = (state_q == ST_BUS) && (cnt_q == CNT_LAST) && !bus_ack_i;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_i && !flush_i) begin
                    if (!is_load(op_in) && !is_store(op_in)) begin
                        write_addr_d   = write_addr_i;
                        write_enable_d = write_enable_i;
                        wdata_d        = ans_i;
                    end else if (!is_aligned(op_in, addr_i[1:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        stall_o    = 1'b1;
                        state_d    = ST_BUS;
                        cnt_d      = '0;
                        op_d       = op_in;
                        off_d      = addr_i[1:0];
                        cap_wa_d   = write_addr_i;
                        cap_we_d   = write_enable_i;
                        discard_d  = 1'b0;
                        bus_req_d  = 1'b1;
                        bus_we_d   = is_store(op_in);
                        bus_addr_d = {addr_i[DATA_W-1:2], 2'b00};
                        unique case (op_in)
                            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
                                bus_sel_d   = 4'b0001 << addr_i[1:0];
                                bus_wdata_d = {4{store_data_i[7:0]}};
                            end
                            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
                                bus_sel_d   = addr_i[1] ? 4'b1100 : 4'b0011;
                                bus_wdata_d = {2{store_data_i[15:0]}};
                            end
                            default: begin
                                bus_sel_d   = 4'b1111;
                                bus_wdata_d = store_data_i;
                            end
                        endcase
                    end
                end
            end
            default: begin
                stall_o = !bus_ack_i && !timeout_hit;
                if (flush_i) discard_d = 1'b1;
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_IDLE;
                    // A flush seen in the ack cycle still kills the write-back.
                    if (is_load(op_q) && !discard_q && !flush_i) begin
                        write_addr_d   = cap_wa_q;
                        write_enable_d = cap_we_q;
                        wdata_d        = load_val;
                    end
                end else if (timeout_hit) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            op_q           <= MEM_OP_NONE;
            off_q          <= 2'b00;
            cap_wa_q       <= '0;
            cap_we_q       <= 1'b0;
            discard_q      <= 1'b0;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_sel_q      <= 4'b0000;
            bus_wdata_q    <= '0;
            write_addr_q   <= '0;
            write_enable_q <= 1'b0;
            wdata_q        <= '0;
            misalign_q     <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            off_q          <= off_d;
            cap_wa_q       <= cap_wa_d;
            cap_we_q       <= cap_we_d;
            discard_q      <= discard_d;
            bus_req_q      <= bus_req_d;
            bus_we_q       <= bus_we_d;
            bus_addr_q     <= bus_addr_d;
            bus_sel_q      <= bus_sel_d;
            bus_wdata_q    <= bus_wdata_d;
            write_addr_q   <= write_addr_d;
            write_enable_q <= write_enable_d;
            wdata_q        <= wdata_d;
            misalign_q     <= misalign_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_sel_o      = bus_sel_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign write_addr_o   = write_addr_q;
    assign write_enable_o = write_enable_q;
    assign wdata_o        = wdata_q;
    assign misalign_o     = misalign_q;
    assign bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with BUS_TIMEOUT=4.
// Inputs change 1ns after a rising edge; outputs are checked 1-2ns later.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [3:0]  mem_op_i;
    logic [31:0] addr_i;
    logic [31:0] ans_i;
    logic [31:0] store_data_i;
    logic [4:0]  write_addr_i;
    logic        write_enable_i;
    logic        flush_i;
    logic        stall_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic [4:0]  write_addr_o;
    logic        write_enable_o;
    logic [31:0] wdata_o;
    logic        misalign_o;
    logic        bus_err_o;

    int total = 0;
    int bad   = 0;

    mem_stage #(
        .DATA_W      (32),
        .REG_ADDR_W  (5),
        .BUS_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .mem_op_i       (mem_op_i),
        .addr_i         (addr_i),
        .ans_i          (ans_i),
        .store_data_i   (store_data_i),
        .write_addr_i   (write_addr_i),
        .write_enable_i (write_enable_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_sel_o      (bus_sel_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_rdata_i    (bus_rdata_i),
        .bus_ack_i      (bus_ack_i),
        .write_addr_o   (write_addr_o),
        .write_enable_o (write_enable_o),
        .wdata_o        (wdata_o),
        .misalign_o     (misalign_o),
        .bus_err_o      (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] wa, input logic we);
        valid_i        = v;
        mem_op_i       = op;
        addr_i         = a;
        store_data_i   = sd;
        write_addr_i   = wa;
        write_enable_i = we;
    endtask

    initial begin
        rst = 1'b0;
        flush_i = 1'b0;
        ans_i = 32'h0;
        bus_rdata_i = 32'h0;
        bus_ack_i = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);

        // reset state
        tick();
        tick();
        chk("rst_req", bus_req_o, 0);
        chk("rst_we", write_enable_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_sel", bus_sel_o, 0);
        chk("rst_mis", misalign_o, 0);
        chk("rst_err", bus_err_o, 0);
        chk("rst_stall", stall_o, 0);
        rst = 1'b1;
        tick();

        // ALU pass-through
        drive(1'b1, 4'd0, 32'h0, 32'h0, 5'd5, 1'b1);
        ans_i = 32'h1234_5678;
        #1 chk("alu_stall", stall_o, 0);
        tick();
        chk("alu_wdata", wdata_o, 32'h1234_5678);
        chk("alu_wa", write_addr_o, 5);
        chk("alu_we", write_enable_o, 1);
        chk("alu_req", bus_req_o, 0);

        // flushed instruction behaves as a bubble
        flush_i = 1'b1;
        ans_i = 32'h5555_0000;
        tick();
        chk("flush_we", write_enable_o, 0);
        flush_i = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        chk("bubble_we", write_enable_o, 0);

        // LW 0x100, ack on the 4th BUS cycle (counter at its last value)
        drive(1'b1, 4'd5, 32'h100, 32'h0, 5'd6, 1'b1);
        #1 chk("lw_stall_idle", stall_o, 1);
        tick();
        chk("lw_req", bus_req_o, 1);
        chk("lw_addr", bus_addr_o, 32'h100);
        chk("lw_sel", bus_sel_o, 4'hF);
        chk("lw_bwe", bus_we_o, 0);
        chk("lw_we_busy", write_enable_o, 0);
        chk("lw_stall0", stall_o, 1);
        tick();
        chk("lw_stall1", stall_o, 1);
        tick();
        chk("lw_stall2", stall_o, 1);
        tick();
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hDEAD_BEEF;
        #1 chk("lw_stall_ack", stall_o, 0);
        chk("lw_req_ack", bus_req_o, 1);
        tick();
        bus_ack_i = 1'b0;
        // LB at 0x103 presented back-to-back
        drive(1'b1, 4'd1, 32'h103, 32'h0, 5'd7, 1'b1);
        chk("lw_wdata", wdata_o, 32'hDEAD_BEEF);
        chk("lw_we", write_enable_o, 1);
        chk("lw_wa", write_addr_o, 6);
        chk("lw_req_done", bus_req_o, 0);
        chk("lw_no_err", bus_err_o, 0);

        // LB 0x103 -> sign extended
        tick();
        chk("lb_sel", bus_sel_o, 4'b1000);
        chk("lb_addr", bus_addr_o, 32'h100);
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h8012_3456;
        tick();
        bus_ack_i = 1'b0;
        drive(1'b1, 4'd2, 32'h103, 32'h0, 5'd8, 1'b1);
        chk("lb_wdata", wdata_o, 32'hFFFF_FF80);
        chk("lb_we", write_enable_o, 1);
        chk("lb_wa", write_addr_o, 7);

        // LBU 0x103 -> zero extended
        tick();
        chk("lbu_sel", bus_sel_o, 4'b1000);
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        drive(1'b1, 4'd7, 32'h202, 32'h0000_ABCD, 5'd9, 1'b1);
        chk("lbu_wdata", wdata_o, 32'h0000_0080);
        chk("lbu_we", write_enable_o, 1);

        // SH 0x202
        tick();
        chk("sh_sel", bus_sel_o, 4'b1100);
        chk("sh_bwdata", bus_wdata_o, 32'hABCD_ABCD);
        chk("sh_bwe", bus_we_o, 1);
        chk("sh_addr", bus_addr_o, 32'h200);
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        drive(1'b1, 4'd5, 32'h101, 32'h0, 5'd10, 1'b1);
        chk("sh_we", write_enable_o, 0);
        chk("sh_req_done", bus_req_o, 0);

        // LW 0x101 misaligned
        #1 chk("mis_stall", stall_o, 0);
        tick();
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        chk("mis_pulse", misalign_o, 1);
        chk("mis_req", bus_req_o, 0);
        chk("mis_we", write_enable_o, 0);
        tick();
        chk("mis_pulse_end", misalign_o, 0);

        // SB 0x001 -> lane 1
        drive(1'b1, 4'd6, 32'h001, 32'h0000_00A5, 5'd0, 1'b0);
        tick();
        chk("sb_sel", bus_sel_o, 4'b0010);
        chk("sb_bwdata", bus_wdata_o, 32'hA5A5_A5A5);
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;

        // LHU 0x012 -> upper half
        drive(1'b1, 4'd4, 32'h012, 32'h0, 5'd11, 1'b1);
        tick();
        chk("lhu_sel", bus_sel_o, 4'b1100);
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h9876_5432;
        tick();
        bus_ack_i = 1'b0;
        chk("lhu_wdata", wdata_o, 32'h0000_9876);

        // timeout: never ack
        drive(1'b1, 4'd5, 32'h040, 32'h0, 5'd12, 1'b1);
        tick();
        chk("to_req0", bus_req_o, 1);
        chk("to_stall0", stall_o, 1);
        tick();
        chk("to_req1", bus_req_o, 1);
        tick();
        chk("to_req2", bus_req_o, 1);
        chk("to_stall2", stall_o, 1);
        tick();
        chk("to_req3", bus_req_o, 1);
        chk("to_stall3", stall_o, 0);
        chk("to_err_early", bus_err_o, 0);
        tick();
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        chk("to_req_drop", bus_req_o, 0);
        chk("to_err", bus_err_o, 1);
        chk("to_we", write_enable_o, 0);
        #1 chk("to_stall_rel", stall_o, 0);
        tick();
        chk("to_err_end", bus_err_o, 0);

        // flush during BUS suppresses the load
        drive(1'b1, 4'd5, 32'h010, 32'h0, 5'd3, 1'b1);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h0000_0001;
        tick();
        bus_ack_i = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        chk("flushbus_we", write_enable_o, 0);
        chk("flushbus_req", bus_req_o, 0);

        // ack while IDLE is ignored
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        chk("idle_ack_we", write_enable_o, 0);
        chk("idle_ack_req", bus_req_o, 0);

        // reset mid-BUS drops the request immediately
        drive(1'b1, 4'd5, 32'h020, 32'h0, 5'd4, 1'b1);
        tick();
        chk("rstbus_req_pre", bus_req_o, 1);
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        #2 rst = 1'b0;
        #1 chk("rstbus_req", bus_req_o, 0);
        chk("rstbus_stall", stall_o, 0);
        #3 rst = 1'b1;
        tick();
        chk("rstbus_req_after", bus_req_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
